// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching processor front end: fetch FSM
// encoding and default bus widths.
package cpu_pkg;

    localparam int unsigned ROM_WIDTH_DEF  = 21;
    localparam int unsigned ADDR_WIDTH_DEF = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t BOOT = 2'd0;
    localparam fetch_state_t RUN  = 2'd1;
    localparam fetch_state_t HALT = 2'd2;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with jump load and increment enables; flags
// wrap-out when an increment leaves the all-ones address.
import cpu_pkg::*;

module pc_reg #(
    parameter int unsigned              ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  inc_en_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  wrap_c
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Jump load takes priority over the sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_addr_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign wrap_c = inc_en_i & (&pc_q);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, ROM addressing, registered instruction with
// valid/ready handoff. Optional PC wrap trap under FETCH_WRAP_TRAP_EN.
import cpu_pkg::*;

module instr_fetch #(
    parameter int unsigned              ROM_WIDTH  = ROM_WIDTH_DEF,
    parameter int unsigned              ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic [ROM_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic                  fetch_err
);

`ifdef FETCH_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fetch_state_t          state_q, state_d;
    logic [ROM_WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  wrap_c;
    logic                  load_c;

    // A jump suppresses the load at its edge; otherwise load when the slot frees.
    assign load_c = (state_q == RUN) && !jump_en && (!valid_q || instr_ready);

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en_i   (jump_en),
        .load_addr_i (jump_addr),
        .inc_en_i    (load_c),
        .pc_o        (pc),
        .wrap_c      (wrap_c)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
        if (load_c) begin
            instr_d = rom_data;
            ipc_d   = pc;
            valid_d = 1'b1;
        end
        if (jump_en) begin
            valid_d = 1'b0;
        end

        case (state_q)
            BOOT:    state_d = halt ? HALT : RUN;
            RUN:     if (!jump_en && halt)  state_d = HALT;
            HALT:    if (!jump_en && !halt) state_d = RUN;
            default: state_d = BOOT;
        endcase

        // Fetching the last address still delivers it, then traps.
        if (TRAP_EN && load_c && wrap_c) begin
            err_d   = 1'b1;
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign ROM_ADDR    = pc;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the fetch unit.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [20:0] rom_data;
    logic [20:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        halt;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ROM_ADDR    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] rom_f(input logic [15:0] a);
        if (a == 16'h0000) return 21'h1D0001;
        if (a == 16'h0001) return 21'h190000;
        return {a, a[4:0]} ^ 21'h0A5A5;
    endfunction

    assign rom_data = rom_f(rom_addr);

`ifdef FETCH_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Behavioural model: mode 0 = boot, 1 = run, 2 = halted.
    int          m_mode  = 0;
    int unsigned m_pc    = 0;
    logic        m_vld   = 1'b0;
    logic [20:0] m_instr = '0;
    int unsigned m_ipc   = 0;
    logic        m_err   = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_vld = 1'b0; m_instr = '0; m_ipc = 0; m_err = 1'b0;
    endtask

    task automatic model_step();
        if (jump_en) begin
            m_pc  = int'(jump_addr);
            m_vld = 1'b0;
            if (m_mode == 0) m_mode = halt ? 2 : 1;
        end else if (m_mode == 0) begin
            m_mode = halt ? 2 : 1;
        end else if (m_mode == 1) begin
            if (!m_vld || instr_ready) begin
                m_instr = rom_f(16'(m_pc));
                m_ipc   = m_pc;
                m_vld   = 1'b1;
                if (halt) m_mode = 2;
                if (TRAP && m_pc == 65535) begin
                    m_err  = 1'b1;
                    m_mode = 2;
                end
                m_pc = (m_pc + 1) % 65536;
            end else if (halt) begin
                m_mode = 2;
            end
        end else begin
            if (m_vld && instr_ready) m_vld = 1'b0;
            if (!halt) m_mode = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_valid", 32'(instr_valid), 32'(m_vld));
            chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
            chk("m_instr", 32'(instr), 32'(m_instr));
            chk("m_instr_pc", 32'(instr_pc), 32'(m_ipc));
            chk("m_fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = '0; halt = 1'b0;
        @(negedge clk); #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(rom_addr), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;

        // Boot edge, then the first load.
        tick();
        chk("boot_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("w0_valid", 32'(instr_valid), 32'd1);
        chk("w0_instr", 32'(instr), 32'h1D0001);
        chk("w0_pc", 32'(instr_pc), 32'd0);
        tick();
        chk("w1_instr", 32'(instr), 32'h190000);
        chk("w1_pc", 32'(instr_pc), 32'd1);
        tick();
        chk("w2_pc", 32'(instr_pc), 32'd2);

        // Stall on word 2.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(instr_pc), 32'd2);
            chk("stall_addr", 32'(rom_addr), 32'd3);
        end
        instr_ready = 1'b1;
        tick();
        chk("after_stall_pc", 32'(instr_pc), 32'd3);
        tick();
        tick();
        chk("pre_jump_pc", 32'(instr_pc), 32'd5);

        // Jump back to 3 while word 5 is consumed.
        jump_en = 1'b1; jump_addr = 16'h0003;
        tick();
        jump_en = 1'b0;
        chk("jump_bubble", 32'(instr_valid), 32'd0);
        chk("jump_addr", 32'(rom_addr), 32'd3);
        tick();
        chk("jump_w_pc", 32'(instr_pc), 32'd3);
        chk("jump_w_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("jump_w2_pc", 32'(instr_pc), 32'd4);

        // Halt with a pending word.
        instr_ready = 1'b0; halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_hold_pc", 32'(instr_pc), 32'd4);
            chk("halt_hold_addr", 32'(rom_addr), 32'd5);
        end
        halt = 1'b0; instr_ready = 1'b1;
        tick();
        chk("unhalt_consume", 32'(instr_valid), 32'd0);
        tick();
        chk("resume_pc", 32'(instr_pc), 32'd5);

        // Wrap at the top of the address space.
        jump_en = 1'b1; jump_addr = 16'hFFFF;
        tick();
        jump_en = 1'b0;
        tick();
        chk("wrap_w_pc", 32'(instr_pc), 32'hFFFF);
        chk("wrap_err", 32'(fetch_err), 32'(TRAP));
        tick();
        if (TRAP) begin
            chk("trap_valid", 32'(instr_valid), 32'd0);
            chk("trap_err_hold", 32'(fetch_err), 32'd1);
        end else begin
            chk("wrap_next_pc", 32'(instr_pc), 32'd0);
            chk("wrap_no_err", 32'(fetch_err), 32'd0);
        end

        // Reset while stalled at pc 7.
        jump_en = 1'b1; jump_addr = 16'h0007;
        tick();
        jump_en = 1'b0;
        tick();
        instr_ready = 1'b0;
        tick();
        chk("stall7_pc", 32'(instr_pc), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", 32'(instr), 32'd0);
        chk("async_addr", 32'(rom_addr), 32'd0);
        chk("async_err", 32'(fetch_err), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        chk("rerst_instr", 32'(instr), 32'h1D0001);
        chk("rerst_pc", 32'(instr_pc), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            jump_en     = ($urandom_range(0, 19) == 0);
            jump_addr   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535))
                                                      : 16'($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
